// File: rtl/imm_ext_stage.sv
// Registered immediate-extension stage between decode and execute.
// Optional long-immediate PREFIX support is enabled with `define IMM_PREFIX_EN.
`timescale 1ns/1ps
module imm_ext_stage #(
    parameter int DATA_W = 16,
    parameter int I_W    = 5,
    parameter int S_W    = 9,
    parameter int J_W    = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic              in_ext_op,
    input  logic [J_W-1:0]    in_field,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_pfx,
    output logic              out_err
);

    localparam int PFX_W = DATA_W - I_W;
    localparam int XW    = (DATA_W > J_W) ? DATA_W : J_W;

    localparam logic [1:0] FMT_I   = 2'b00;
    localparam logic [1:0] FMT_S   = 2'b01;
    localparam logic [1:0] FMT_PFX = 2'b11;

    if (J_W < PFX_W) begin : g_param_check
        $error("imm_ext_stage: J_W must be >= DATA_W - I_W");
    end

    // Extend the low 'width' bits of field to DATA_W; bits above 'width' are ignored.
    function automatic logic [DATA_W-1:0] extend(input logic [J_W-1:0] field,
                                                 input int width,
                                                 input logic sext);
        logic [XW-1:0]     wide;
        logic [DATA_W-1:0] res;
        logic              fill;
        wide = XW'(field);
        fill = sext & wide[width-1];
        for (int i = 0; i < DATA_W; i++) begin
            res[i] = (i < width) ? wide[i] : fill;
        end
        return res;
    endfunction

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_imm_q, out_imm_d;
    logic              out_pfx_q, out_pfx_d;
    logic              out_err_q, out_err_d;
    logic [DATA_W-1:0] ext_imm;
    logic              accept;

`ifdef IMM_PREFIX_EN
    typedef enum logic {
        PFX_IDLE = 1'b0,
        PFX_HELD = 1'b1
    } pfx_state_e;

    pfx_state_e        state_q, state_d;
    logic [PFX_W-1:0]  pfx_reg_q, pfx_reg_d;
`endif

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        ext_imm = '0;
        case (in_fmt)
            FMT_I:   ext_imm = extend(in_field, I_W, in_ext_op);
            FMT_S:   ext_imm = extend(in_field, S_W, in_ext_op);
            default: ext_imm = extend(in_field, J_W, in_ext_op);
        endcase
    end

    // Flush outranks acceptance: a same-cycle input is dropped.
    always_comb begin
        out_valid_d = out_valid_q;
        out_imm_d   = out_imm_q;
        out_pfx_d   = out_pfx_q;
        out_err_d   = out_err_q;
`ifdef IMM_PREFIX_EN
        state_d     = state_q;
        pfx_reg_d   = pfx_reg_q;
`endif
        if (flush) begin
            out_valid_d = 1'b0;
            out_pfx_d   = 1'b0;
            out_err_d   = 1'b0;
`ifdef IMM_PREFIX_EN
            state_d     = PFX_IDLE;
            pfx_reg_d   = '0;
`endif
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_pfx_d   = 1'b0;
            out_err_d   = 1'b0;
            if (in_fmt == FMT_PFX) begin
                out_imm_d = '0;
`ifdef IMM_PREFIX_EN
                out_pfx_d = 1'b1;
                pfx_reg_d = in_field[PFX_W-1:0];
                state_d   = PFX_HELD;
`else
                out_err_d = 1'b1;
`endif
            end else begin
                out_imm_d = ext_imm;
`ifdef IMM_PREFIX_EN
                // A held prefix supplies the upper bits; ext_op and format width are ignored.
                if (state_q == PFX_HELD) begin
                    out_imm_d = {pfx_reg_q, in_field[I_W-1:0]};
                    state_d   = PFX_IDLE;
                end
`endif
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_imm_q   <= '0;
            out_pfx_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_imm_q   <= out_imm_d;
            out_pfx_q   <= out_pfx_d;
            out_err_q   <= out_err_d;
        end
    end

`ifdef IMM_PREFIX_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PFX_IDLE;
            pfx_reg_q <= '0;
        end else begin
            state_q   <= state_d;
            pfx_reg_q <= pfx_reg_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign out_imm   = out_imm_q;
    assign out_pfx   = out_pfx_q;
    assign out_err   = out_err_q;

endmodule
